// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl
//   Sequencer for a gated clock multiplexer. It owns the mux select and the
//   gate enable. A source change happens only once the gate has been closed
//   for GATE_WAIT cycles. The gate reopens only after the new source has
//   settled for SETTLE_WAIT cycles. Switch requests arrive over valid/ready.
//
// Ports
//   i_clk           free-running control clock
//   i_rst_n         asynchronous reset, active low
//   i_run_req       1 = output clock requested running
//   i_sw_valid      switch request valid
//   i_sw_sel        requested source, sampled on accept
//   o_sw_ready      request can be accepted (decoded from state)
//   o_sel           mux select (registered)
//   o_en            clock gate enable (registered)
//   o_busy          switch sequence in progress (DRAIN or SELECT)
//   o_switch_done   one-cycle pulse when a switch completes
module clk_switch_ctrl #(
  parameter int unsigned GATE_WAIT   = 2,
  parameter int unsigned SETTLE_WAIT = 2,
  parameter int unsigned CNT_W       = 4,
  parameter logic        SEL_RST     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run_req,
  input  logic i_sw_valid,
  input  logic i_sw_sel,
  output logic o_sw_ready,
  output logic o_sel,
  output logic o_en,
  output logic o_busy,
  output logic o_switch_done
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_ON     = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SELECT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_WAIT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sel;
  logic             r_en;
  logic             r_busy;
  logic             r_done;
  logic             r_target;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_sel_nxt;
  logic             w_en_nxt;
  logic             w_done_nxt;
  logic             w_target_nxt;
  logic             w_ready;
  logic             w_accept;

  // Requests are only taken in the two idle states.
  assign w_ready  = (r_state == ST_OFF) || (r_state == ST_ON);
  assign w_accept = i_sw_valid & w_ready;

  // State register plus registered copies of every output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_OFF;
      r_cnt    <= CNT_ZERO;
      r_sel    <= SEL_RST;
      r_en     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_target <= SEL_RST;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sel    <= w_sel_nxt;
      r_en     <= w_en_nxt;
      r_busy   <= (w_state_nxt == ST_DRAIN) || (w_state_nxt == ST_SELECT);
      r_done   <= w_done_nxt;
      r_target <= w_target_nxt;
    end
  end

  // Next-state, counter and output sequencing.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sel_nxt    = r_sel;
    w_en_nxt     = r_en;
    w_done_nxt   = 1'b0;
    w_target_nxt = r_target;
    case (r_state)
      ST_OFF: begin
        if (w_accept) begin
          w_target_nxt = i_sw_sel;
          if (i_sw_sel != r_sel) begin
            // The gate is already closed, so the select can move at once.
            w_state_nxt = ST_SELECT;
            w_sel_nxt   = i_sw_sel;
            w_cnt_nxt   = SETTLE_LOAD;
          end else begin
            w_done_nxt = 1'b1;
          end
        end else if (i_run_req) begin
          w_state_nxt = ST_ON;
          w_en_nxt    = 1'b1;
        end else begin
          w_state_nxt = ST_OFF;
        end
      end
      ST_ON: begin
        if (w_accept) begin
          w_target_nxt = i_sw_sel;
          if (i_sw_sel != r_sel) begin
            w_state_nxt = ST_DRAIN;
            w_en_nxt    = 1'b0;
            w_cnt_nxt   = GATE_LOAD;
          end else begin
            w_done_nxt = 1'b1;
          end
        end else if (!i_run_req) begin
          w_state_nxt = ST_OFF;
          w_en_nxt    = 1'b0;
        end else begin
          w_state_nxt = ST_ON;
        end
      end
      ST_DRAIN: begin
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = ST_SELECT;
          w_sel_nxt   = r_target;
          w_cnt_nxt   = SETTLE_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_SELECT: begin
        if (r_cnt == CNT_ZERO) begin
          // run_req is only looked at again here, on leaving SELECT.
          w_done_nxt = 1'b1;
          if (i_run_req) begin
            w_state_nxt = ST_ON;
            w_en_nxt    = 1'b1;
          end else begin
            w_state_nxt = ST_OFF;
            w_en_nxt    = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
        w_en_nxt    = 1'b0;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  assign o_sw_ready    = w_ready;
  assign o_sel         = r_sel;
  assign o_en          = r_en;
  assign o_busy        = r_busy;
  assign o_switch_done = r_done;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed testbench for clk_switch_ctrl (GATE_WAIT=SETTLE_WAIT=2, SEL_RST=0).
// Inputs change 1 ns after each rising edge. Outputs are checked at that same
// point. A negedge monitor checks the sel/en invariant on every cycle.
module tb_clk_switch_ctrl;

  logic clk;
  logic rst_n;
  logic run_req;
  logic sw_valid;
  logic sw_sel;
  logic sw_ready;
  logic sel;
  logic en;
  logic busy;
  logic switch_done;

  int checks = 0;
  int errors = 0;

  clk_switch_ctrl #(
    .GATE_WAIT   (2),
    .SETTLE_WAIT (2),
    .CNT_W       (4),
    .SEL_RST     (1'b0)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_run_req     (run_req),
    .i_sw_valid    (sw_valid),
    .i_sw_sel      (sw_sel),
    .o_sw_ready    (sw_ready),
    .o_sel         (sel),
    .o_en          (en),
    .o_busy        (busy),
    .o_switch_done (switch_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // The invariant: sel may only change when en is low now and was low last cycle.
  // Cycles around a reset are excluded because reset moves sel asynchronously.
  logic prev_sel;
  logic prev_en;
  logic prev_rst_ok;
  initial begin
    prev_sel    = 1'b0;
    prev_en     = 1'b0;
    prev_rst_ok = 1'b0;
  end
  always @(negedge clk) begin
    if (rst_n === 1'b1 && prev_rst_ok && sel !== prev_sel) begin
      chk("inv_en_now", en, 1'b0);
      chk("inv_en_prev", prev_en, 1'b0);
    end
    prev_sel    = sel;
    prev_en     = en;
    prev_rst_ok = (rst_n === 1'b1);
  end

  initial begin
    rst_n    = 1'b0;
    run_req  = 1'b0;
    sw_valid = 1'b0;
    sw_sel   = 1'b0;

    // Reset state
    #12;
    chk("rst_en", en, 1'b0);
    chk("rst_sel", sel, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", switch_done, 1'b0);
    chk("rst_ready", sw_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // run_req at cycle 3 -> en at cycle 4
    step(3);
    chk("off_en", en, 1'b0);
    run_req = 1'b1;
    step(1);
    chk("on_en", en, 1'b1);
    chk("on_sel", sel, 1'b0);
    chk("on_ready", sw_ready, 1'b1);

    // Switch from ON: en=0 @1, sel=1 @3, en=1 + done @5, busy @1..4
    sw_valid = 1'b1; sw_sel = 1'b1;
    step(1);                       // cycle 1
    sw_valid = 1'b0;
    chk("sw1_c1_en", en, 1'b0);
    chk("sw1_c1_busy", busy, 1'b1);
    chk("sw1_c1_sel", sel, 1'b0);
    chk("sw1_c1_ready", sw_ready, 1'b0);
    step(1);                       // cycle 2
    chk("sw1_c2_sel", sel, 1'b0);
    chk("sw1_c2_busy", busy, 1'b1);
    step(1);                       // cycle 3
    chk("sw1_c3_sel", sel, 1'b1);
    chk("sw1_c3_en", en, 1'b0);
    step(1);                       // cycle 4
    chk("sw1_c4_busy", busy, 1'b1);
    chk("sw1_c4_en", en, 1'b0);
    chk("sw1_c4_done", switch_done, 1'b0);
    step(1);                       // cycle 5
    chk("sw1_c5_en", en, 1'b1);
    chk("sw1_c5_done", switch_done, 1'b1);
    chk("sw1_c5_busy", busy, 1'b0);
    step(1);
    chk("sw1_c6_done", switch_done, 1'b0);

    // Same-source request while ON: no gating, done next cycle
    sw_valid = 1'b1; sw_sel = 1'b1;
    step(1);
    sw_valid = 1'b0;
    chk("same_en", en, 1'b1);
    chk("same_done", switch_done, 1'b1);
    chk("same_busy", busy, 1'b0);
    chk("same_sel", sel, 1'b1);
    step(1);
    chk("same_done_clr", switch_done, 1'b0);

    // Switch from OFF: sel @1, done @3, en stays 0
    run_req = 1'b0;
    step(1);
    chk("goff_en", en, 1'b0);
    sw_valid = 1'b1; sw_sel = 1'b0;
    step(1);                       // cycle 1
    sw_valid = 1'b0;
    chk("off_c1_sel", sel, 1'b0);
    chk("off_c1_busy", busy, 1'b1);
    chk("off_c1_en", en, 1'b0);
    step(1);                       // cycle 2
    chk("off_c2_done", switch_done, 1'b0);
    step(1);                       // cycle 3
    chk("off_c3_done", switch_done, 1'b1);
    chk("off_c3_en", en, 1'b0);
    chk("off_c3_busy", busy, 1'b0);
    step(1);
    chk("off_c4_done", switch_done, 1'b0);
    chk("off_c4_en", en, 1'b0);

    // run_req dropped during DRAIN; a held request while busy is not taken
    run_req = 1'b1;
    step(1);
    chk("on2_en", en, 1'b1);
    sw_valid = 1'b1; sw_sel = 1'b1;
    step(1);                       // cycle 1 (DRAIN)
    sw_valid = 1'b0;
    run_req  = 1'b0;
    chk("drop_c1_en", en, 1'b0);
    step(1);                       // cycle 2
    sw_valid = 1'b1; sw_sel = 1'b0;   // busy: must not be accepted
    chk("drop_c2_ready", sw_ready, 1'b0);
    step(1);                       // cycle 3
    sw_valid = 1'b0;
    chk("drop_c3_sel", sel, 1'b1);
    step(2);                       // cycle 5
    chk("drop_c5_done", switch_done, 1'b1);
    chk("drop_c5_en", en, 1'b0);
    chk("drop_c5_sel", sel, 1'b1);
    step(1);
    chk("drop_c6_en", en, 1'b0);
    chk("drop_c6_done", switch_done, 1'b0);

    // Reset during SELECT: back to sel=0, en=0, busy=0 immediately
    run_req = 1'b1;
    step(1);
    sw_valid = 1'b1; sw_sel = 1'b0;
    step(1);
    sw_valid = 1'b0;
    step(4);                       // sel now 0, ON at cycle 5
    chk("rs_pre_en", en, 1'b1);
    chk("rs_pre_sel", sel, 1'b0);
    sw_valid = 1'b1; sw_sel = 1'b1;
    step(1);
    sw_valid = 1'b0;
    step(2);                       // cycle 3: SELECT, sel=1
    chk("rs_sel_before", sel, 1'b1);
    chk("rs_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rs_en", en, 1'b0);
    chk("rs_sel", sel, 1'b0);
    chk("rs_busy", busy, 1'b0);
    chk("rs_done", switch_done, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("rs_after_en", en, 1'b1);
    chk("rs_after_sel", sel, 1'b0);
    chk("rs_after_done", switch_done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
